// File: rtl/control_sequencer.sv
// control_sequencer -- microinstruction sequencer for an SAP-1 style CPU.
//
// A ring of timing states T1..T6 (plus an absorbing HALT) drives the
// register-transfer control lines of the datapath. T1-T3 fetch the next
// instruction. T4-T6 execute it, with the controls decoded from the
// instruction-register opcode nibble. All controls are combinational
// functions of the current state and opcode. They are held at 0 while
// reset is asserted.
//
// Optional feature: define SAP_VARIABLE_CYCLE_EN to return to T1 right
// after the last useful step. LDA then ends after T5, and OUT and NOP end
// after T4. ADD and SUB still use all six states. Without the macro,
// every non-HLT instruction takes exactly six states.
//
// Ports:
//   clock            rising-edge system clock
//   reset            asynchronous, active-high reset (forces T1)
//   opcode[3:0]      instruction opcode, only looked at in T4-T6
//   pc_out, pc_inc   program counter bus drive / increment
//   mar_in, ram_out  memory address register load / RAM bus drive
//   ir_in, ir_out    instruction register load / operand bus drive
//   a_in, a_out      accumulator load / bus drive
//   b_in             B register load
//   alu_out, alu_sub ALU bus drive / subtract select
//   out_in           output register load
//   halted           high while in HALT
//   t_state[2:0]     current state: T1..T6 = 0..5, HALT = 7
module control_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       out_in,
    output logic       halted,
    output logic [2:0] t_state
);

    typedef enum logic [2:0] {
        T1   = 3'd0,
        T2   = 3'd1,
        T3   = 3'd2,
        T4   = 3'd3,
        T5   = 3'd4,
        T6   = 3'd5,
        HALT = 3'd7
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_out;
    logic is_hlt;

    assign is_lda = (opcode == OP_LDA);
    assign is_add = (opcode == OP_ADD);
    assign is_sub = (opcode == OP_SUB);
    assign is_out = (opcode == OP_OUT);
    assign is_hlt = (opcode == OP_HLT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= T1;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_out     = 1'b0;
        pc_inc     = 1'b0;
        mar_in     = 1'b0;
        ram_out    = 1'b0;
        ir_in      = 1'b0;
        ir_out     = 1'b0;
        a_in       = 1'b0;
        a_out      = 1'b0;
        b_in       = 1'b0;
        alu_out    = 1'b0;
        alu_sub    = 1'b0;
        out_in     = 1'b0;

        case (state_reg)
            T1: begin
                pc_out     = 1'b1;
                mar_in     = 1'b1;
                state_next = T2;
            end
            T2: begin
                pc_inc     = 1'b1;
                state_next = T3;
            end
            T3: begin
                ram_out    = 1'b1;
                ir_in      = 1'b1;
                state_next = T4;
            end
            T4: begin
                if (is_lda || is_add || is_sub) begin
                    ir_out = 1'b1;
                    mar_in = 1'b1;
                end else if (is_out) begin
                    a_out  = 1'b1;
                    out_in = 1'b1;
                end
                if (is_hlt) begin
                    state_next = HALT;
                end else begin
`ifdef SAP_VARIABLE_CYCLE_EN
                    // Only LDA/ADD/SUB have work left after T4.
                    state_next = (is_lda || is_add || is_sub) ? T5 : T1;
`else
                    state_next = T5;
`endif
                end
            end
            T5: begin
                if (is_lda) begin
                    ram_out = 1'b1;
                    a_in    = 1'b1;
                end else if (is_add || is_sub) begin
                    ram_out = 1'b1;
                    b_in    = 1'b1;
                end
`ifdef SAP_VARIABLE_CYCLE_EN
                state_next = is_lda ? T1 : T6;
`else
                state_next = T6;
`endif
            end
            T6: begin
                if (is_add || is_sub) begin
                    alu_out = 1'b1;
                    a_in    = 1'b1;
                    alu_sub = is_sub;
                end
                state_next = T1;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                // The unused encoding 6 recovers to the start of a fetch.
                state_next = T1;
            end
        endcase

        // While reset is asserted, all controls are held at 0, whatever
        // the (already forced) state decodes to.
        if (reset) begin
            pc_out  = 1'b0;
            pc_inc  = 1'b0;
            mar_in  = 1'b0;
            ram_out = 1'b0;
            ir_in   = 1'b0;
            ir_out  = 1'b0;
            a_in    = 1'b0;
            a_out   = 1'b0;
            b_in    = 1'b0;
            alu_out = 1'b0;
            alu_sub = 1'b0;
            out_in  = 1'b0;
        end
    end

    assign halted  = (state_reg == HALT);
    assign t_state = state_reg;

endmodule
